// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// Operands and result each travel over their own valid/ready pair.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_carry;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;

  modport slave (
    input  i_valid, i_a, i_b, i_carry, i_ready,
    output o_ready, o_valid, o_sum, o_carry
  );

  modport master (
    output i_valid, i_a, i_b, i_carry, i_ready,
    input  o_ready, o_valid, o_sum, o_carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder consumes one bit pair per clock, LSB first,
// with the running carry held in a flip-flop between cycles.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt, sum_q;
  logic [CW-1:0]    cnt;
  logic             c_q, carry_q;
  logic             fa_s, fa_co;
  logic             ready, accept, last;

  full_adder u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0 holds the LSB.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = fa_s;
    end else begin : g_resn
      assign res_nxt = {fa_s, res[WIDTH-1:1]};
    end
  endgenerate

  assign ready       = (state == IDLE) & ~i_rst;
  assign accept      = bus.i_valid & ready;
  assign last        = (cnt == CW'(WIDTH - 1));

  assign bus.o_ready = ready;
  assign bus.o_valid = (state == DONE);
  assign bus.o_sum   = sum_q;
  assign bus.o_carry = carry_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh <= bus.i_a;
            b_sh <= bus.i_b;
            c_q  <= bus.i_carry;
            cnt  <= '0;
            res  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_nxt;
          c_q  <= fa_co;
          cnt  <= cnt + CW'(1);
          // Result registers hold until the next completion; only reset clears them.
          if (last) begin
            sum_q   <= res_nxt;
            carry_q <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1 with a per-DUT expected-result queue.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(1)) b1 ();

  serial_adder #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(b8));
  serial_adder #(.WIDTH(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction; hold = cycles of backpressure in DONE, busy = push new operands during RUN.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input int hold, input bit busy);
    logic [8:0] exp;
    int n;
    b8.i_a = a; b8.i_b = b; b8.i_carry = c; b8.i_valid = 1'b1;
    chk({tag, "_ready"}, 32'(b8.o_ready), 32'd1);
    tick();
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    b8.i_valid = 1'b0;
    if (busy) begin
      b8.i_valid = 1'b1; b8.i_a = ~a; b8.i_b = ~b; b8.i_carry = ~c;
    end
    n = 0;
    while (!b8.o_valid && n < 40) begin
      if (busy) chk({tag, "_busy_ready"}, 32'(b8.o_ready), 32'd0);
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_sb_size"}, 32'(q8.size()), 32'd1);
    exp = (q8.size() != 0) ? q8.pop_front() : 9'h1ff;
    chk({tag, "_result"}, 32'({b8.o_carry, b8.o_sum}), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(b8.o_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'({b8.o_carry, b8.o_sum}), 32'(exp));
    end
    b8.i_valid = 1'b0;
    b8.i_ready = 1'b1;
    tick();
    b8.i_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(b8.o_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(b8.o_ready), 32'd1);
    chk({tag, "_retained"}, 32'({b8.o_carry, b8.o_sum}), 32'(exp));
  endtask

  task automatic run1(input logic a, input logic b, input logic c);
    logic [1:0] exp;
    int n;
    b1.i_a = a; b1.i_b = b; b1.i_carry = c; b1.i_valid = 1'b1;
    chk("w1_ready", 32'(b1.o_ready), 32'd1);
    tick();
    q1.push_back(2'(a) + 2'(b) + 2'(c));
    b1.i_valid = 1'b0;
    n = 0;
    while (!b1.o_valid && n < 10) begin
      tick();
      n++;
    end
    chk("w1_latency", 32'(n), 32'd1);
    exp = (q1.size() != 0) ? q1.pop_front() : 2'bxx;
    chk($sformatf("w1_result_%0d%0d%0d", a, b, c), 32'({b1.o_carry, b1.o_sum}), 32'(exp));
    b1.i_ready = 1'b1;
    tick();
    b1.i_ready = 1'b0;
    chk("w1_valid_drop", 32'(b1.o_valid), 32'd0);
  endtask

  initial begin
    b8.i_valid = 1'b0; b8.i_ready = 1'b0; b8.i_a = '0; b8.i_b = '0; b8.i_carry = 1'b0;
    b1.i_valid = 1'b0; b1.i_ready = 1'b0; b1.i_a = '0; b1.i_b = '0; b1.i_carry = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(b8.o_valid), 32'd0);
    chk("rst_ready", 32'(b8.o_ready), 32'd0);
    chk("rst_result", 32'({b8.o_carry, b8.o_sum}), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(b8.o_ready), 32'd1);

    run8("zero", 8'h00, 8'h00, 1'b0, 0, 1'b0);
    run8("ripple", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run8("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 0, 1'b0);
    run8("37_4c", 8'h37, 8'h4C, 1'b0, 0, 1'b0);
    run8("backpressure", 8'hC3, 8'h7E, 1'b1, 5, 1'b0);
    run8("busy_input", 8'h5C, 8'h21, 1'b0, 0, 1'b1);

    // Reset in the middle of a computation discards the partial result.
    b8.i_a = 8'h12; b8.i_b = 8'h34; b8.i_carry = 1'b1; b8.i_valid = 1'b1;
    tick();
    q8.push_back(9'h047);
    b8.i_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrun_rst_valid", 32'(b8.o_valid), 32'd0);
    chk("midrun_rst_result", 32'({b8.o_carry, b8.o_sum}), 32'd0);
    chk("midrun_rst_ready", 32'(b8.o_ready), 32'd0);
    q8.delete();
    rst = 1'b0;
    #1;
    run8("after_rst", 8'h10, 8'h20, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run1(v[2], v[1], v[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
